// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants used by both the program loader and the core decode path.
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Values 5..7 are deliberately left out; the encoder flags them illegal.
  typedef enum logic [2:0] {
    ClsRAlu   = 3'd0,
    ClsIAlu   = 3'd1,
    ClsLoad   = 3'd2,
    ClsStore  = 3'd3,
    ClsBranch = 3'd4
  } instr_class_e;

  typedef enum logic [1:0] {
    StLoading,
    StFlush,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Field-bundle stream into the program loader: valid/ready plus pre-split instruction fields.
interface program_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [12:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Combinational RV32I encoder: instruction fields in, 32-bit word and illegal-class flag out.
module instr_encoder
  import rv_isa_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Branch offsets are always even, so imm bit 0 carries no information.
  logic unused_imm0;
  assign unused_imm0 = imm_i[0];

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (instr_class_e'(cls_i))
      ClsRAlu:   word_o = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      ClsIAlu:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
      ClsLoad:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
      ClsStore:  word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
      ClsBranch: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                           OP_BRANCH};
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: encodes field bundles and writes them to imem from address 0,
// holding the core in reset until the last word has landed.
module program_loader
  import rv_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  program_loader_if.slave     in_bus,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                core_hold,
  output logic                done,
  output logic                err
);

  loader_state_e     state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              flush_err_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_hold_q;
  logic              done_q;
  logic              err_q;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;
  logic        at_last_addr;

  instr_encoder u_encoder (
    .cls_i      (in_bus.in_class),
    .rd_i       (in_bus.in_rd),
    .rs1_i      (in_bus.in_rs1),
    .rs2_i      (in_bus.in_rs2),
    .funct3_i   (in_bus.in_funct3),
    .funct7b5_i (in_bus.in_funct7b5),
    .imm_i      (in_bus.in_imm),
    .word_o     (enc_word),
    .illegal_o  (enc_illegal)
  );

  assign in_bus.in_ready = (state_q == StLoading) && !rst;
  assign accept          = in_bus.in_valid && in_bus.in_ready;
  assign at_last_addr    = (cnt_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoading;
      cnt_q        <= '0;
      flush_err_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      unique case (state_q)
        StLoading: begin
          if (accept) begin
            if (enc_illegal) begin
              state_q <= StError;
              err_q   <= 1'b1;
            end else begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= cnt_q;
              imem_wdata_q <= enc_word;
              cnt_q        <= cnt_q + 1'b1;
              // A last bundle at the top address is a clean finish, not an overflow.
              if (in_bus.in_last) begin
                state_q     <= StFlush;
                flush_err_q <= 1'b0;
              end else if (at_last_addr) begin
                state_q     <= StFlush;
                flush_err_q <= 1'b1;
              end
            end
          end
        end
        StFlush: begin
          if (flush_err_q) begin
            state_q <= StError;
            err_q   <= 1'b1;
          end else begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            core_hold_q <= 1'b0;
          end
        end
        StDone, StError: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader for the single-cycle RV32I core. Accepts pre-split instruction fields over a valid/ready stream, encodes them into 32-bit RV32I words, and writes them to consecutive instruction-memory addresses starting at 0. It is the encoding counterpart of the core's control-unit decode path and holds the core in reset until the program has been fully written.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2**ADDR_W words.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  loader can accept a bundle.
- `in_class`  in  3  instruction class: 0 = R-ALU, 1 = I-ALU, 2 = LOAD (lw), 3 = STORE (sw), 4 = BRANCH; 5–7 are illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3  funct3 field.
- `in_funct7b5`  in  1  instruction bit 30; used by R-ALU only.
- `in_imm`  in  13  two's-complement immediate. I/S use [11:0]; B uses [12:1], and bit 0 is ignored.
- `in_last`  in  1  marks the final bundle of the program.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `core_hold`  out  1  keeps the core in reset while high.
- `done`  out  1  program fully written.
- `err`  out  1  illegal class or overflow.

## Operation
- **Reset values:**
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_hold`=1, `done`=0, `err`=0.
  - `in_ready`=0 while `rst` is high.
  - Write counter = 0. State = LOADING.
- **FSM states:**
  - LOADING: `in_ready`=1.
  - FLUSH: `in_ready`=0; the last write is in flight.
  - DONE: `in_ready`=0, `done`=1, `core_hold`=0.
  - ERROR: `in_ready`=0, `err`=1, `core_hold`=1.
- DONE and ERROR are sticky and are left only by `rst`.
- **Accept:** a bundle is accepted when `in_valid & in_ready` is high at a clock edge.
- **Encoding** (opcode / layout):
  - R: 0110011, with `funct7b5` in bit 30 and all other funct7 bits 0.
  - I-ALU: 0010011, imm[11:0] in inst[31:20].
  - LOAD: 0000011, funct3 from `in_funct3`.
  - STORE: 0100011, imm[11:5] in inst[31:25], imm[4:0] in inst[11:7].
  - BRANCH: 1100011, imm[12]→31, imm[10:5]→30:25, imm[4:1]→11:8, imm[11]→7.
  - Fields that a format does not use are ignored.
- **Legal accept in LOADING:**
  - The encoded word is registered and written on the next cycle at the current counter value.
  - The counter increments by 1 after each write.
- **Accept with `in_last`=1:** go to FLUSH, then DONE.
- **Illegal class:** go directly to ERROR. Nothing is written and the counter is unchanged.
- **Overflow:** a legal, non-last bundle accepted while the counter = 2**ADDR_W−1 is still written, then the block goes to ERROR. A last bundle at that address completes normally into DONE.
- If an illegal class and `in_last` arrive together, the illegal class wins and the block goes to ERROR.
- **`rst` mid-load:** return to the reset state immediately. A write pending from the previous cycle is dropped (`imem_we`=0 on the cycle after the reset edge).

## Timing
- Latency: bundle accepted at edge N → `imem_we`=1 during cycle N+1 with `imem_addr`/`imem_wdata` valid.
- Throughput: one bundle per cycle in LOADING; back-to-back accepts produce consecutive addresses with no bubbles.
- `in_ready` is combinational from state: it drops in the cycle after the accepting edge of a last or illegal bundle.
- For a last bundle accepted at edge N: the write occurs in cycle N+1, and `done`=1 and `core_hold`=0 from cycle N+2.
- For an illegal bundle accepted at edge N: `err`=1 from cycle N+1.
- For an overflow bundle accepted at edge N: the write occurs in cycle N+1 and `err`=1 from cycle N+2.
- All outputs are registered except `in_ready`.

## Structure
- A shared package `rv_isa_pkg` holds:
  - opcode localparams `OP_R`, `OP_I`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`;
  - funct3 constants `F3_BEQ`=000, `F3_BNE`=001, `F3_BLT`=100, `F3_LW`/`F3_SW`=010;
  - the class encoding;
  - the state enum.
- The decoding side of the core consumes the same opcode/funct3 constants.
- Sub-module `instr_encoder`: purely combinational, mapping fields to a 32-bit word plus an `illegal` flag. The top level holds the FSM, the counter and the output registers.

## Test plan
- Accept class 1, rd=1, rs1=0, f3=000, imm=5 → cycle N+1: `imem_we`=1, addr 0, wdata 0x00500093.
- Back-to-back R-type: rd=3, rs1=1, rs2=2, f7b5=0, then f7b5=1 → addr 0 = 0x002081B3, addr 1 = 0x402081B3; no idle cycle between the writes.
- Stream lw x4,4(x0); sw x2,8(x0); beq x1,x2,imm=−4 with `in_last`=1:
  - expected words 0x00402203, 0x00202423, 0xFE208EE3 at addrs 0–2;
  - `done`=1 and `core_hold`=0 two cycles after the last accept;
  - `in_ready`=0 from then on.
- `in_class`=6 on the second bundle:
  - addr 0 is written, no second write;
  - `err`=1 and `core_hold`=1 next cycle;
  - `in_ready` stays 0 until `rst`.
- ADDR_W=2, four legal bundles with no `in_last` → writes to addrs 0–3, then `err`=1 and `done`=0.
- Assert `rst` in the cycle after an accept:
  - no write occurs, and `imem_addr`=0;
  - reloading from addr 0 succeeds.
